// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and constants for the div_sched scheduler.
//   state_t   : FSM state encoding (IDLE, LOAD, RUN, DONE).
//   DEF_*     : default requester count and counter width.
//   MAX_*     : largest configuration lim_slice() can address.
//   lim_slice : extracts limit slice idx (width cw) from a packed limit bus.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_CW    = 16;
  localparam int unsigned MAX_NREQ  = 8;
  localparam int unsigned MAX_CW    = 32;
  localparam int unsigned LIM_BUS_W = MAX_NREQ * MAX_CW;

  // Caller zero-extends its limit bus to LIM_BUS_W and truncates the result
  // to its own counter width; bits above cw belong to the next slice.
  function automatic logic [MAX_CW-1:0] lim_slice(
    input logic [LIM_BUS_W-1:0] lims,
    input int unsigned          idx,
    input int unsigned          cw
  );
    return MAX_CW'(lims >> (idx * cw));
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: requester-side bundle of the shared divider scheduler.
//   req     : per-requester request level
//   cnt_lim : packed limits, slice i = cnt_lim[i*CW +: CW]
//   gnt     : one-hot grant (LOAD/RUN)
//   done    : one-cycle completion pulse
//   busy    : scheduler not in IDLE
//   cnt     : shared counter value
//   s_clk   : divided-clock level
// master = requesters, slave = div_sched.
interface div_sched_if
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CW   = DEF_CW
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] cnt_lim;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      cnt;
  logic               s_clk;

  modport master (
    output req, cnt_lim,
    input  gnt, done, busy, cnt, s_clk
  );

  modport slave (
    input  req, cnt_lim,
    output gnt, done, busy, cnt, s_clk
  );

endinterface

// File: rtl/div_sched_rr_pick.sv
// rr_pick: combinational round-robin priority select.
//   req   in  NREQ : request levels
//   last  in  IW   : index served most recently
//   valid out 1    : any request set
//   idx   out IW   : first set req bit searching upward from last+1, wrapping
module rr_pick
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!valid && req[IW'((32'(last) + k) % NREQ)]) begin
        valid = 1'b1;
        idx   = IW'((32'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler time-sharing one terminal-count counter
// among NREQ requesters.
//   clk   in : system clock
//   reset in : synchronous, active-high
//   bus      : div_sched_if.slave (req, cnt_lim in; gnt, done, busy, cnt,
//              s_clk out)
// Service: IDLE picks a requester and latches its limit, LOAD clears the
// counter, RUN counts 0..limit, DONE pulses done and returns to IDLE.
// Dropping req of the served requester in LOAD/RUN aborts without done.
// Optional macro DIV_SCHED_TOGGLE_EN: s_clk inverts on every DONE; when
// undefined, s_clk is tied low. Requires CW <= 32 and NREQ <= 8.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned CW   = DEF_CW
) (
  input logic        clk,
  input logic        reset,
  div_sched_if.slave bus
);

  localparam int unsigned   IW       = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   last, last_n;
  logic [CW-1:0]   lim, lim_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [NREQ-1:0] done_q, done_n;
  logic            busy_q, busy_n;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Outputs are registered: their next values are decoded from the next
  // state, so they line up with the state they describe.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    lim_n   = lim;
    cnt_n   = cnt_q;
    gnt_n   = '0;
    done_n  = '0;
    busy_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = LOAD;
          idx_n   = pick_idx;
          lim_n   = CW'(lim_slice(LIM_BUS_W'(bus.cnt_lim), 32'(pick_idx), CW));
          cnt_n   = '0;
        end
      end
      LOAD: begin
        if (!bus.req[idx]) begin
          state_n = IDLE;
          last_n  = idx;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        // Abort takes priority over completion.
        if (!bus.req[idx]) begin
          state_n = IDLE;
          last_n  = idx;
        end else if (cnt_q == lim) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        last_n  = idx;
      end
      default: state_n = IDLE;
    endcase

    if (state_n == LOAD || state_n == RUN) gnt_n[idx_n] = 1'b1;
    if (state_n == DONE)                   done_n[idx_n] = 1'b1;
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      last   <= LAST_RST;
      lim    <= '0;
      cnt_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      last   <= last_n;
      lim    <= lim_n;
      cnt_q  <= cnt_n;
      gnt_q  <= gnt_n;
      done_q <= done_n;
      busy_q <= busy_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.cnt  = cnt_q;

`ifdef DIV_SCHED_TOGGLE_EN
  logic s_clk_q;

  always_ff @(posedge clk) begin
    if (reset)                 s_clk_q <= 1'b0;
    else if (state_n == DONE)  s_clk_q <= ~s_clk_q;
  end

  assign bus.s_clk = s_clk_q;
`else
  assign bus.s_clk = 1'b0;
`endif

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized scoreboard bench for div_sched.
// A batch planner turns request sets into a service schedule (who is served,
// from which cycle, for how long); a monitor checks the DUT against the
// head of that schedule every cycle.
module tb_div_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  div_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

  div_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int s;    // IDLE cycle in which the requester is picked
    int idx;
    int lim;
    int d;    // abort: req dropped in cycle s+1+d
    bit ab;
  } svc_t;

  svc_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  logic sclk_exp = 1'b0;
  int   model_last = NREQ - 1;
  int   b_lim[NREQ];
  int   b_ab[NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_next(input int last, input logic [NREQ-1:0] pend);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: per-cycle comparison against the head service.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic [NREQ-1:0] eg, ed;
        logic            eb;
        bit              cchk;
        int              ec, hi, endc;
        svc_t            e;
        eg = '0; ed = '0; eb = 1'b0; cchk = 1'b0; ec = 0;
        if (sb.size() > 0) begin
          e    = sb[0];
          hi   = e.ab ? e.s + 1 + e.d : e.s + 2 + e.lim;
          endc = e.ab ? hi : e.s + 3 + e.lim;
          if (cyc >= e.s + 1 && cyc <= hi) begin
            eg[e.idx] = 1'b1;
            cchk = 1'b1;
            ec = (cyc <= e.s + 2) ? 0 : cyc - e.s - 2;
          end
          if (!e.ab && cyc == endc) begin
            ed[e.idx] = 1'b1;
            cchk = 1'b1;
            ec = e.lim;
`ifdef DIV_SCHED_TOGGLE_EN
            sclk_exp = ~sclk_exp;
`endif
          end
          eb = (cyc >= e.s + 1 && cyc <= endc);
          if (cyc == endc) void'(sb.pop_front());
        end
        check("gnt", 64'(bus.gnt), 64'(eg));
        check("done", 64'(bus.done), 64'(ed));
        check("busy", 64'(bus.busy), 64'(eb));
        if (cchk) check("cnt", 64'(bus.cnt), 64'(ec));
        check("s_clk", 64'(bus.s_clk), 64'(sclk_exp));
      end
    end
  end

  task automatic clr_b();
    for (int i = 0; i < NREQ; i++) begin
      b_lim[i] = 0;
      b_ab[i]  = -1;
    end
  endtask

  // Called at a negedge while the DUT is idle with no request pending.
  task automatic run_batch(input logic [NREQ-1:0] mask);
    svc_t            plan[$];
    svc_t            e;
    logic [NREQ-1:0] pend;
    int              t;
    t    = cyc;
    pend = mask;
    for (int i = 0; i < NREQ; i++) bus.cnt_lim[i*CW +: CW] = CW'(b_lim[i]);
    while (pend != '0) begin
      e.idx = rr_next(model_last, pend);
      e.s   = t;
      e.lim = b_lim[e.idx];
      e.ab  = (b_ab[e.idx] >= 0);
      e.d   = b_ab[e.idx];
      t     = e.ab ? t + 2 + e.d : t + 4 + e.lim;
      model_last = e.idx;
      pend[e.idx] = 1'b0;
      plan.push_back(e);
      sb.push_back(e);
    end
    bus.req = mask;
    while (cyc < t) begin
      @(negedge clk);
      foreach (plan[k]) begin
        // Served limit is latched; disturbing it afterwards must not matter.
        if (cyc == plan[k].s + 1) bus.cnt_lim[plan[k].idx*CW +: CW] = CW'($urandom);
        if (plan[k].ab && cyc == plan[k].s + 1 + plan[k].d) bus.req[plan[k].idx] = 1'b0;
        if (!plan[k].ab && cyc == plan[k].s + 3 + plan[k].lim) bus.req[plan[k].idx] = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   64'(bus.gnt),   64'(0));
    check({tag, "_done"},  64'(bus.done),  64'(0));
    check({tag, "_busy"},  64'(bus.busy),  64'(0));
    check({tag, "_cnt"},   64'(bus.cnt),   64'(0));
    check({tag, "_s_clk"}, 64'(bus.s_clk), 64'(0));
  endtask

  initial begin
    reset       = 1'b1;
    bus.req     = '0;
    bus.cnt_lim = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // All four requesters, limit 1: order 0,1,2,3 from reset.
    clr_b();
    for (int i = 0; i < NREQ; i++) b_lim[i] = 1;
    run_batch(4'b1111);
    // Single request, limit 3.
    clr_b(); b_lim[0] = 3;
    run_batch(4'b0001);
    // Limit 0 on requester 2.
    clr_b(); b_lim[2] = 0;
    run_batch(4'b0100);
    // Requester 1 aborts with cnt==2, requester 2 pending.
    clr_b(); b_lim[1] = 10; b_ab[1] = 3; b_lim[2] = 2;
    run_batch(4'b0110);
    // Abort in LOAD.
    clr_b(); b_lim[3] = 5; b_ab[3] = 0;
    run_batch(4'b1000);
    // Requester 0 re-requesting with limit 2.
    clr_b(); b_lim[0] = 2;
    repeat (4) run_batch(4'b0001);

    // Reset in the middle of RUN.
    mon_en = 1'b0;
    bus.cnt_lim[0 +: CW] = CW'(10);
    bus.req = 4'b0001;
    repeat (4) @(negedge clk);
    check("pre_reset_gnt", 64'(bus.gnt), 64'(1));
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check_all_zero("midrun_reset");
    reset = 1'b0;
    @(negedge clk);
    model_last = NREQ - 1;
    sclk_exp   = 1'b0;
    mon_en     = 1'b1;
    clr_b();
    for (int i = 0; i < NREQ; i++) b_lim[i] = i + 1;
    run_batch(4'b1111);

    // Random batches.
    for (int n = 0; n < 30; n++) begin
      clr_b();
      for (int i = 0; i < NREQ; i++) begin
        b_lim[i] = int'($urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) b_ab[i] = int'($urandom_range(0, b_lim[i]));
      end
      run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    end

    // Full-scale limit.
    clr_b(); b_lim[3] = 65535;
    run_batch(4'b1000);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
